audio_adc_rx: RTL and testbench
===============================

// Module: audio_adc_rx
// PURPOSE
//  Codec ADC capture stage; pairs with the DAC serializer on the same codec link. Generates adclrck frame pulse,
//  deserializes adcdat MSB-first into 16-bit left/right samples, buffers stereo pairs in a small FIFO and presents
//  them on a valid/ready stream to downstream processing (filter/loopback into the DAC path).
// PARAMETERS
//  SAMPLE_W    16   bits per channel sample (two's complement)
//  FRAME_LEN   251  clk cycles per stereo frame; must equal the DAC frame period; FRAME_LEN >= 2*SAMPLE_W+2
//  FIFO_DEPTH  2    stereo-pair buffer entries; power of 2, >= 2
// PORTS
//  clk          in   1         system clock; bclk/xck are this same clock, so adcdat is sampled directly
//  reset        in   1         asynchronous, active-high reset
//  enable       in   1         1 = run frame counter and capture; 0 = idle
//  adcdat       in   1         serial ADC data from codec
//  adclrck      out  1         one-cycle frame-start pulse to codec
//  s_left       out  SAMPLE_W  head-of-FIFO left sample
//  s_right      out  SAMPLE_W  head-of-FIFO right sample
//  s_valid      out  1         FIFO not empty
//  s_ready      in   1         consumer accepts head pair when s_valid&&s_ready at posedge clk
//  overrun      out  1         sticky: a completed pair was dropped on full FIFO
//  overrun_clr  in   1         clears overrun
//  peak_mag     out  SAMPLE_W-1 (only with AUDIO_ADC_PEAK_EN) peak |sample| since last clear
//  peak_clr     in   1         (only with AUDIO_ADC_PEAK_EN) clears peak_mag
// BEHAVIOUR
//  - All logic on posedge clk; reset async active-high. Reset values: adclrck=0, s_valid=0, s_left=s_right=0,
//    overrun=0, peak_mag=0, frame counter cnt=0, FIFO empty, shift registers 0.
//  - cnt runs 0..FRAME_LEN-1 then wraps to 0 while enable=1. enable=0: cnt forced to 0, adclrck=0, shift regs
//    cleared, partial frame discarded; FIFO contents and stream output unaffected (still drainable).
//  - adclrck registered; high for exactly the cycle in which cnt==0 with enable=1; low otherwise.
//  - Capture: at edge with cnt==k, k=1..SAMPLE_W: left={left[W-2:0],adcdat}; k=SAMPLE_W+1..2*SAMPLE_W: same
//    into right. First captured bit is MSB. Bits at cnt>2*SAMPLE_W are ignored.
//  - Pair complete at edge with cnt==2*SAMPLE_W+1: push {left,right}. s_valid rises the next cycle if FIFO
//    was empty (first-word fall-through; s_left/s_right valid whenever s_valid=1, stable until popped).
//  - Full FIFO + push without pop: new pair dropped, FIFO unchanged, overrun<=1. Full + push + pop same edge:
//    pop and push both performed, no overrun. Empty + pop impossible (s_valid=0 ignores s_ready).
//  - overrun_clr and a new overrun event on same edge: overrun stays 1 (set wins).
//  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
//  - Reset mid-frame or mid-stream: everything returns to reset values immediately; first adclrck pulse occurs
//    in the first cycle with reset=0 and enable=1.
// CONFIGURATION
//  AUDIO_ADC_PEAK_EN defined: peak_mag/peak_clr ports exist; on each accepted push peak_mag<=max(peak_mag,
//    |left|,|right|); |x| saturates (-32768 -> 32767). peak_clr with same-edge push: peak_mag<=max(|left|,|right|)
//    of that pair; peak_clr alone: 0. Dropped pairs do not update peak.
//  AUDIO_ADC_PEAK_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - audio_pkg: SAMPLE_W and FRAME_LEN defaults, stereo_pair_t {left,right}, abs-saturate function.
//  - Sub-module audio_pair_fifo (push/pop/full/empty, FWFT head output, DEPTH param); frame counter, shift regs,
//    overrun and peak logic in top.
// TESTING
//  1 Reset: assert reset mid-frame at cnt=40 -> all outputs 0 same cycle; after release adclrck pulses once per
//    251 cycles, first in first enabled cycle.
//  2 Capture: drive left=16'hA5C3, right=16'h1234 MSB-first at cnt 1..32 -> s_valid at cnt 34, s_left=A5C3,
//    s_right=1234; s_ready=1 pops, s_valid=0 next cycle.
//  3 Overrun: s_ready=0 for 3 frames (pairs P0,P1,P2) -> FIFO holds P0,P1, overrun=1, P2 lost; drain returns
//    P0 then P1; overrun_clr -> overrun=0.
//  4 Full+pop same edge: FIFO full, s_ready=1 exactly at push edge -> no overrun, order preserved.
//  5 enable drop at cnt=10 then re-enable -> no pair pushed for partial frame, next full frame captured correctly.
//  6 (AUDIO_ADC_PEAK_EN) pairs (0x8000,0x0010) then (0x0100,0x7FF0) -> peak_mag=7FFF; peak_clr with next push
//    of (0x0005,0xFFFE) -> peak_mag=0005.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the codec ADC capture path: sample width, frame/FIFO defaults,
// the stereo pair record and a saturating magnitude function.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DEF_FRAME_LEN  = 251;
    localparam int DEF_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_pair_t;

    // Magnitude of a two's complement sample; the most negative code saturates to all ones.
    function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = (~x) + SAMPLE_W'(1);
        if (!x[SAMPLE_W-1]) begin
            return x[SAMPLE_W-2:0];
        end
        if (neg[SAMPLE_W-1]) begin
            return '1;
        end
        return neg[SAMPLE_W-2:0];
    endfunction

    function automatic logic [SAMPLE_W-2:0] max_mag(input logic [SAMPLE_W-2:0] a,
                                                     input logic [SAMPLE_W-2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/audio_adc_rx_if.sv
// Valid/ready stream carrying one stereo sample pair per transfer.
interface audio_adc_rx_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_left, output s_right, output s_valid, input s_ready);
    modport slave  (input s_left, input s_right, input s_valid, output s_ready);

endinterface

// File: rtl/audio_pair_fifo.sv
// First-word fall-through FIFO of stereo pairs; the head entry is always visible on 'head'.
module audio_pair_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  stereo_pair_t push_data,
    input  logic         pop,
    output stereo_pair_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    stereo_pair_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC capture: frame counter with adclrck pulse, MSB-first left/right deserializer, pair FIFO
// and sticky overrun flag. Define AUDIO_ADC_PEAK_EN to add the peak_mag/peak_clr peak-magnitude tracker.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  adcdat,
    output logic                  adclrck,
    audio_adc_rx_if.master        stream,
    output logic                  overrun,
    input  logic                  overrun_clr
`ifdef AUDIO_ADC_PEAK_EN
    ,
    output logic [SAMPLE_W-2:0]   peak_mag,
    input  logic                  peak_clr
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] L_FIRST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] R_FIRST  = CNT_W'(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(2 * SAMPLE_W);
    localparam logic [CNT_W-1:0] PUSH_AT  = CNT_W'(2 * SAMPLE_W + 1);

    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] left_sh;
    logic [SAMPLE_W-1:0] right_sh;
    stereo_pair_t        push_data;
    stereo_pair_t        head;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                drop;

    // Dropping enable abandons the partial frame; the FIFO keeps whatever it already holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            adclrck  <= 1'b0;
            left_sh  <= '0;
            right_sh <= '0;
        end else if (!enable) begin
            cnt      <= '0;
            adclrck  <= 1'b0;
            left_sh  <= '0;
            right_sh <= '0;
        end else begin
            adclrck <= (cnt == '0);
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt >= L_FIRST && cnt <= L_LAST) begin
                left_sh <= {left_sh[SAMPLE_W-2:0], adcdat};
            end else if (cnt >= R_FIRST && cnt <= R_LAST) begin
                right_sh <= {right_sh[SAMPLE_W-2:0], adcdat};
            end
        end
    end

    assign push      = enable && (cnt == PUSH_AT);
    assign push_data = '{left: left_sh, right: right_sh};
    assign pop       = stream.s_valid && stream.s_ready;
    assign drop      = push && full && !pop;

    audio_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign stream.s_valid = !empty;
    assign stream.s_left  = head.left;
    assign stream.s_right = head.right;

    // A fresh overrun on the clearing edge wins so no lost pair goes unreported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef AUDIO_ADC_PEAK_EN
    logic                push_accepted;
    logic [SAMPLE_W-2:0] pair_mag;

    assign push_accepted = push && !drop;
    assign pair_mag      = max_mag(abs_sat(push_data.left), abs_sat(push_data.right));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_mag <= '0;
        end else if (push_accepted) begin
            peak_mag <= peak_clr ? pair_mag : max_mag(peak_mag, pair_mag);
        end else if (peak_clr) begin
            peak_mag <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx: directed frames, a vector table and random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_audio_adc_rx;

    localparam int FRAME = 251;
    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_left;
        logic [15:0] exp_right;
        logic        exp_ov;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic adcdat;
    logic adclrck;
    logic overrun;
    logic overrun_clr;
`ifdef AUDIO_ADC_PEAK_EN
    logic [14:0] peak_mag;
    logic        peak_clr;
    int          m_peak;
`endif

    audio_adc_rx_if sif();

    audio_adc_rx dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .adcdat      (adcdat),
        .adclrck     (adclrck),
        .stream      (sif),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef AUDIO_ADC_PEAK_EN
        ,
        .peak_mag    (peak_mag),
        .peak_clr    (peak_clr)
`endif
    );

    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          m_cnt;
    logic        m_bits [32];
    logic [31:0] m_q [$];
    logic        m_ov;
    logic        m_lrck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_ov   = 1'b0;
        m_lrck = 1'b0;
        m_q.delete();
`ifdef AUDIO_ADC_PEAK_EN
        m_peak = 0;
`endif
    endfunction

    // One clock edge of the reference: frame position, bit collection, queue and flags.
    function automatic void model_step();
        logic        pop;
        logic        accept;
        logic        drop;
        logic [15:0] l;
        logic [15:0] r;
        if (reset) begin
            model_reset();
            return;
        end
        pop    = (m_q.size() > 0) && sif.s_ready;
        accept = 1'b0;
        drop   = 1'b0;
        l      = '0;
        r      = '0;
        if (enable) begin
            if (m_cnt >= 1 && m_cnt <= 32) m_bits[m_cnt-1] = adcdat;
            if (m_cnt == 33) begin
                for (int i = 0; i < 16; i++) begin
                    l[15-i] = m_bits[i];
                    r[15-i] = m_bits[16+i];
                end
                if (m_q.size() < DEPTH || pop) accept = 1'b1;
                else drop = 1'b1;
            end
            m_lrck = (m_cnt == 0);
            m_cnt  = (m_cnt + 1) % FRAME;
        end else begin
            m_lrck = 1'b0;
            m_cnt  = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (accept) m_q.push_back({l, r});
        if (drop) m_ov = 1'b1;
        else if (overrun_clr) m_ov = 1'b0;
`ifdef AUDIO_ADC_PEAK_EN
        if (accept) begin
            int pm;
            pm = (mag(l) > mag(r)) ? mag(l) : mag(r);
            if (peak_clr) m_peak = pm;
            else if (pm > m_peak) m_peak = pm;
        end else if (peak_clr) begin
            m_peak = 0;
        end
`endif
    endfunction

    task automatic checkOutput();
        check("adclrck", 32'(adclrck), 32'(m_lrck));
        check("s_valid", 32'(sif.s_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("s_left", 32'(sif.s_left), 32'(m_q[0][31:16]));
            check("s_right", 32'(sif.s_right), 32'(m_q[0][15:0]));
        end
        check("overrun", 32'(overrun), 32'(m_ov));
`ifdef AUDIO_ADC_PEAK_EN
        check("peak_mag", 32'(peak_mag), 32'(m_peak));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    function automatic logic bit_for(input int c, input logic [15:0] l, input logic [15:0] r);
        if (c >= 1 && c <= 16) return l[16-c];
        if (c >= 17 && c <= 32) return r[32-c];
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input int n, input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < n; i++) begin
            adcdat = bit_for(m_cnt, l, r);
            tick();
        end
    endtask

    task automatic run_until_cnt(input int target, input logic [15:0] l, input logic [15:0] r);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 300) begin
            adcdat = bit_for(m_cnt, l, r);
            tick();
            guard++;
        end
        total++;
        if (m_cnt != target) begin
            bad++;
            $display("[TB] FAIL run_until_cnt: got %0d expected %0d", m_cnt, target);
        end
    endtask

    vec_t vecs [3];
    int   pulses [$];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{16'hA5C3, 16'h1234, 1'b0, 1'b1, 16'hA5C3, 16'h1234, 1'b0};
        vecs[1] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'hA5C3, 16'h1234, 1'b0};
        vecs[2] = '{16'h3333, 16'h4444, 1'b0, 1'b1, 16'hA5C3, 16'h1234, 1'b1};

        reset       = 1'b1;
        enable      = 1'b1;
        adcdat      = 1'b0;
        overrun_clr = 1'b0;
        sif.s_ready = 1'b0;
`ifdef AUDIO_ADC_PEAK_EN
        peak_clr    = 1'b0;
`endif
        model_reset();
        tick();
        tick();
        check("rst_left", 32'(sif.s_left), 32'h0);
        check("rst_right", 32'(sif.s_right), 32'h0);
        reset = 1'b0;

        // Reset mid-frame with a pair already buffered, then pulse spacing.
        run_until_cnt(40, 16'h9876, 16'h5432);
        check("pre_rst_valid", 32'(sif.s_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("arst_lrck", 32'(adclrck), 32'h0);
        check("arst_valid", 32'(sif.s_valid), 32'h0);
        check("arst_left", 32'(sif.s_left), 32'h0);
        check("arst_right", 32'(sif.s_right), 32'h0);
        check("arst_ov", 32'(overrun), 32'h0);
`ifdef AUDIO_ADC_PEAK_EN
        check("arst_peak", 32'(peak_mag), 32'h0);
`endif
        model_reset();
        tick();
        reset = 1'b0;
        sif.s_ready = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            adcdat = logic'($urandom_range(0, 1));
            tick();
            if (adclrck) pulses.push_back(c);
        end
        check("pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("pulse_first", 32'(pulses[0]), 32'd1);
            check("pulse_2nd", 32'(pulses[1]), 32'd252);
            check("pulse_3rd", 32'(pulses[2]), 32'd503);
        end
        run_until_cnt(0, 16'h0, 16'h0);
        sif.s_ready = 1'b0;

        // Single capture and pop timing.
        run_until_cnt(33, 16'hA5C3, 16'h1234);
        check("t2_valid_cnt33", 32'(sif.s_valid), 32'h0);
        applyStimulus(1, 16'hA5C3, 16'h1234);
        check("t2_valid_cnt34", 32'(sif.s_valid), 32'h1);
        check("t2_left", 32'(sif.s_left), 32'hA5C3);
        check("t2_right", 32'(sif.s_right), 32'h1234);
        sif.s_ready = 1'b1;
        applyStimulus(1, 16'h0, 16'h0);
        check("t2_popped", 32'(sif.s_valid), 32'h0);
        sif.s_ready = 1'b0;
        run_until_cnt(0, 16'h0, 16'h0);

        // Vector table: fill, fill to full, overrun drop.
        foreach (vecs[i]) begin
            sif.s_ready = vecs[i].ready;
            applyStimulus(FRAME, vecs[i].left, vecs[i].right);
            check($sformatf("tbl%0d_valid", i), 32'(sif.s_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_left", i), 32'(sif.s_left), 32'(vecs[i].exp_left));
                check($sformatf("tbl%0d_right", i), 32'(sif.s_right), 32'(vecs[i].exp_right));
            end
            check($sformatf("tbl%0d_ov", i), 32'(overrun), 32'(vecs[i].exp_ov));
        end

        // Drain order after overrun, then clear.
        sif.s_ready = 1'b1;
        applyStimulus(1, 16'h0, 16'h0);
        check("t3_head1_left", 32'(sif.s_left), 32'h0F0F);
        check("t3_head1_right", 32'(sif.s_right), 32'hF0F0);
        applyStimulus(1, 16'h0, 16'h0);
        check("t3_empty", 32'(sif.s_valid), 32'h0);
        check("t3_ov_sticky", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        applyStimulus(1, 16'h0, 16'h0);
        overrun_clr = 1'b0;
        check("t3_ov_clr", 32'(overrun), 32'h0);
        run_until_cnt(0, 16'h0, 16'h0);
        sif.s_ready = 1'b0;

        // Full FIFO with a pop on the push edge.
        applyStimulus(FRAME, 16'h1357, 16'h2468);
        applyStimulus(FRAME, 16'hAAAA, 16'h5555);
        run_until_cnt(33, 16'hCAFE, 16'hBEEF);
        sif.s_ready = 1'b1;
        applyStimulus(1, 16'hCAFE, 16'hBEEF);
        sif.s_ready = 1'b0;
        check("t4_ov", 32'(overrun), 32'h0);
        check("t4_head_left", 32'(sif.s_left), 32'hAAAA);
        run_until_cnt(0, 16'h0, 16'h0);
        sif.s_ready = 1'b1;
        applyStimulus(1, 16'h0, 16'h0);
        check("t4_next_left", 32'(sif.s_left), 32'hCAFE);
        check("t4_next_right", 32'(sif.s_right), 32'hBEEF);
        applyStimulus(1, 16'h0, 16'h0);
        check("t4_empty", 32'(sif.s_valid), 32'h0);
        run_until_cnt(0, 16'h0, 16'h0);
        sif.s_ready = 1'b0;

        // Enable dropped mid-frame discards the partial pair.
        run_until_cnt(10, 16'h1111, 16'h2222);
        enable = 1'b0;
        applyStimulus(5, 16'h1111, 16'h2222);
        check("t5_lrck_off", 32'(adclrck), 32'h0);
        check("t5_no_push", 32'(sif.s_valid), 32'h0);
        enable = 1'b1;
        applyStimulus(FRAME, 16'h0ABC, 16'h0DEF);
        check("t5_valid", 32'(sif.s_valid), 32'h1);
        check("t5_left", 32'(sif.s_left), 32'h0ABC);
        check("t5_right", 32'(sif.s_right), 32'h0DEF);
        sif.s_ready = 1'b1;
        applyStimulus(FRAME, 16'h0, 16'h0);
        sif.s_ready = 1'b0;

`ifdef AUDIO_ADC_PEAK_EN
        peak_clr = 1'b1;
        applyStimulus(1, 16'h0, 16'h0);
        peak_clr = 1'b0;
        check("t6_clr", 32'(peak_mag), 32'h0);
        sif.s_ready = 1'b1;
        applyStimulus(FRAME - 1, 16'h8000, 16'h0010);
        applyStimulus(FRAME, 16'h0100, 16'h7FF0);
        check("t6_peak", 32'(peak_mag), 32'h7FFF);
        run_until_cnt(33, 16'h0005, 16'hFFFE);
        peak_clr = 1'b1;
        applyStimulus(1, 16'h0005, 16'hFFFE);
        peak_clr = 1'b0;
        check("t6_clr_push", 32'(peak_mag), 32'h0005);
        run_until_cnt(0, 16'h0, 16'h0);
        sif.s_ready = 1'b0;
`endif

        // Random traffic against the reference model.
        begin
            int dis;
            dis = 0;
            for (int f = 0; f < 20; f++) begin
                int pr;
                pr = $urandom_range(0, 4);
                for (int i = 0; i < FRAME; i++) begin
                    sif.s_ready = ($urandom_range(0, 3) < pr);
                    adcdat      = logic'($urandom_range(0, 1));
                    overrun_clr = ($urandom_range(0, 63) == 0);
`ifdef AUDIO_ADC_PEAK_EN
                    peak_clr    = ($urandom_range(0, 96) == 0);
`endif
                    if (dis > 0) begin
                        dis--;
                        if (dis == 0) enable = 1'b1;
                    end else if ($urandom_range(0, 399) == 0) begin
                        enable = 1'b0;
                        dis    = $urandom_range(1, 20);
                    end
                    tick();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
